aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
Iterative AES round sequencer. It accepts one block request, then drives the registered round datapath (sub_bytes -> shift_rows -> mix_columns -> add_round_key) around its feedback loop for NUM_ROUNDS rounds. On the final round it bypasses mix_columns and holds the result under a valid/ready output handshake. It also supplies the round index to the key expander, owns the datapath enable and flush, and detects a datapath that never returns valid.

Parameters:
NUM_ROUNDS, 10, total rounds after the initial key add (10/12/14 for AES-128/192/256); must be 1..15.
DP_LAT, 4, cycles from dp_valid_o to the matching dp_valid_i; must be >= 1.
TIMEOUT, 64, cycles allowed in WAIT before an error is raised; must be > DP_LAT.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
in_valid_i  input  1  new block request.
in_ready_o  output  1  controller can accept a block.
load_o  output  1  1-cycle pulse: datapath selects plaintext XOR key0 instead of feedback.
dp_en_o  output  1  enable to all datapath stage registers.
dp_valid_o  output  1  1-cycle round-issue strobe into the datapath valid chain.
dp_valid_i  input  1  valid returned from the last datapath stage.
dp_flush_o  output  1  1-cycle pulse clearing the datapath valid chain.
round_o  output  4  current round index; also the key expander round select.
mc_bypass_o  output  1  skip mix_columns; high exactly when round_o == NUM_ROUNDS.
abort_i  input  1  synchronous abort of the block in flight.
out_valid_o  output  1  result is held in the datapath output register.
out_ready_i  input  1  consumer accepts the result.
err_o  output  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; round_o = 0; timeout counter = 0.
  - load_o, dp_en_o, dp_valid_o, dp_flush_o, out_valid_o and err_o are all 0.
- in_ready_o is combinational: (state == IDLE) && !abort_i.
- States are IDLE, ISSUE, WAIT and DONE.
- IDLE:
  - On accept (in_valid_i && in_ready_o) in the same cycle: load_o = 1 and dp_en_o = 1.
  - Next cycle: round_o = 1, err_o cleared, state = ISSUE.
  - Otherwise dp_en_o = 0.
- ISSUE (exactly 1 cycle):
  - dp_valid_o = 1, dp_en_o = 1.
  - Timeout counter cleared; next state = WAIT.
- WAIT:
  - dp_en_o = 1; the timeout counter increments each cycle.
  - On dp_valid_i with round_o < NUM_ROUNDS: round_o increments and next state = ISSUE.
  - On dp_valid_i with round_o == NUM_ROUNDS: next state = DONE.
  - If the counter reaches TIMEOUT - 1 without dp_valid_i: err_o is set, dp_flush_o pulses in the following cycle, round_o = 0, state = IDLE.
- DONE:
  - out_valid_o = 1, dp_en_o = 0 (output frozen), round_o holds NUM_ROUNDS.
  - On out_ready_i: next state = IDLE, round_o = 0.
  - out_valid_o stays high until accepted; there is no back-to-back accept, because in_ready_o is 0 while in DONE.
- Round timing:
  - Round r issues at cycle 1 + (r-1)(DP_LAT+1), counted relative to the accept cycle (cycle 0).
  - out_valid_o first rises at cycle NUM_ROUNDS(DP_LAT+1) + 1 (51 with defaults).
- mc_bypass_o = (round_o == NUM_ROUNDS), combinational from the round register.
- abort_i:
  - In ISSUE, WAIT or DONE it has priority over dp_valid_i, out_ready_i and timeout.
  - Next cycle: state = IDLE, round_o = 0, out_valid_o = 0, dp_flush_o = 1 for one cycle.
  - err_o is unchanged.
  - In IDLE it only blocks accept.
- dp_valid_i outside WAIT is ignored and causes no state change.
- Reset asserted mid-block returns immediately to the reset values; no flush pulse is required.
- Timeout counter width is $clog2(TIMEOUT+1) and it saturates; round_o never exceeds NUM_ROUNDS.

Test Plan:
- Defaults, bench datapath echoes dp_valid_o after 4 cycles; accept at cycle 0 -> load_o at cycle 0, dp_valid_o pulses at cycles 1,6,...,46, mc_bypass_o high only during round 10, out_valid_o rises at cycle 51.
- Hold out_ready_i = 0 for 20 cycles in DONE -> out_valid_o stays 1, dp_en_o = 0, in_ready_o = 0; on out_ready_i = 1, IDLE and in_ready_o = 1 next cycle.
- Abort during WAIT of round 5 -> next cycle state IDLE, round_o = 0, dp_flush_o one-cycle pulse; a late dp_valid_i is ignored; a new block then completes normally.
- Datapath never returns dp_valid_i in round 3 (TIMEOUT = 64) -> err_o = 1 after 64 WAIT cycles, dp_flush_o pulse, IDLE; err_o stays 1 until the next accept clears it.
- Same-cycle abort_i and in_valid_i in IDLE -> in_ready_o = 0, no load_o, state stays IDLE.
- NUM_ROUNDS = 14, DP_LAT = 1 -> 14 dp_valid_o pulses every 2 cycles, out_valid_o at cycle 29; assert rst_n low mid-round 7 -> all outputs 0 and round_o = 0 immediately.

Source files
------------

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the AES round sequencer and its
// environment (block source, round datapath, key expander, result consumer).
interface aes_round_ctrl_if;
  logic       in_valid_i;
  logic       in_ready_o;
  logic       load_o;
  logic       dp_en_o;
  logic       dp_valid_o;
  logic       dp_valid_i;
  logic       dp_flush_o;
  logic [3:0] round_o;
  logic       mc_bypass_o;
  logic       abort_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       err_o;

  // Sequencer side.
  modport slave (
    input  in_valid_i,
    output in_ready_o,
    output load_o,
    output dp_en_o,
    output dp_valid_o,
    input  dp_valid_i,
    output dp_flush_o,
    output round_o,
    output mc_bypass_o,
    input  abort_i,
    output out_valid_o,
    input  out_ready_i,
    output err_o
  );

  // Environment side: block source, datapath model and result consumer.
  modport master (
    output in_valid_i,
    input  in_ready_o,
    input  load_o,
    input  dp_en_o,
    input  dp_valid_o,
    output dp_valid_i,
    input  dp_flush_o,
    input  round_o,
    input  mc_bypass_o,
    output abort_i,
    input  out_valid_o,
    output out_ready_i,
    input  err_o
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: issues one round at a time into the registered
// round datapath, waits for it to come back, and holds the final result for the consumer.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned DP_LAT     = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  aes_round_ctrl_if.slave  bus
);

  // A timeout shorter than the datapath latency would fire on every round; clamp it.
  localparam int unsigned TMO_EFF = (TIMEOUT > DP_LAT) ? TIMEOUT : (DP_LAT + 1);
  localparam int          CNT_W   = $clog2(TMO_EFF + 1);

  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TMO_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [3:0]       LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e           state_r;
  state_e           state_s;
  logic [3:0]       round_r;
  logic [3:0]       round_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic             err_r;
  logic             err_s;
  logic             flush_r;
  logic             flush_s;
  logic             dp_valid_r;
  logic             out_valid_r;
  logic             dp_en_s;
  logic             in_ready_s;
  logic             accept_s;

  assign in_ready_s = (state_r == ST_IDLE) && !bus.abort_i;
  assign accept_s   = in_ready_s && bus.in_valid_i;

  // Next-state, round, timeout and flag computation.
  always_comb begin
    state_s = state_r;
    round_s = round_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    flush_s = 1'b0;
    dp_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_ISSUE;
          round_s = 4'd1;
          err_s   = 1'b0;
          dp_en_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        dp_en_s = 1'b1;
        cnt_s   = {CNT_W{1'b0}};
        if (bus.abort_i) begin
          state_s = ST_IDLE;
          round_s = 4'd0;
          flush_s = 1'b1;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dp_en_s = 1'b1;
        if (cnt_r != CNT_MAX) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
        // Abort outranks a returning round, which outranks the timeout.
        if (bus.abort_i) begin
          state_s = ST_IDLE;
          round_s = 4'd0;
          flush_s = 1'b1;
        end else if (bus.dp_valid_i) begin
          if (round_r < LAST_ROUND) begin
            round_s = round_r + 4'd1;
            state_s = ST_ISSUE;
          end else begin
            state_s = ST_DONE;
          end
        end else if (cnt_r >= TMO_LAST) begin
          err_s   = 1'b1;
          flush_s = 1'b1;
          round_s = 4'd0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DONE: begin
        dp_en_s = 1'b0;
        if (bus.abort_i) begin
          state_s = ST_IDLE;
          round_s = 4'd0;
          flush_s = 1'b1;
        end else if (bus.out_ready_i) begin
          state_s = ST_IDLE;
          round_s = 4'd0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        round_s = 4'd0;
        flush_s = 1'b1;
      end
    endcase
  end

  // State, round, counter and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      round_r     <= 4'd0;
      cnt_r       <= {CNT_W{1'b0}};
      err_r       <= 1'b0;
      flush_r     <= 1'b0;
      dp_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      round_r     <= round_s;
      cnt_r       <= cnt_s;
      err_r       <= err_s;
      flush_r     <= flush_s;
      dp_valid_r  <= (state_s == ST_ISSUE);
      out_valid_r <= (state_s == ST_DONE);
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.load_o      = accept_s;
  assign bus.dp_en_o     = dp_en_s;
  assign bus.dp_valid_o  = dp_valid_r;
  assign bus.dp_flush_o  = flush_r;
  assign bus.round_o     = round_r;
  assign bus.mc_bypass_o = (round_r == LAST_ROUND);
  assign bus.out_valid_o = out_valid_r;
  assign bus.err_o       = err_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: a default instance (10 rounds, latency 4) and
// an AES-256 style instance (14 rounds, latency 1), each with a modelled datapath.
module tb_aes_round_ctrl;
  localparam int NA = 10;
  localparam int LA = 4;
  localparam int NB = 14;
  localparam int LB = 1;
  localparam int TMO = 64;

  typedef struct {
    int cyc;
    int round;
  } iss_t;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  logic kill_a;
  logic inject_a;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  iss_t iq_a[$];
  iss_t iq_b[$];
  int   dq_a[$];
  int   dq_b[$];

  logic [LA-1:0] pipe_a;
  logic [LB-1:0] pipe_b;

  aes_round_ctrl_if a_if ();
  aes_round_ctrl_if b_if ();

  aes_round_ctrl #(.NUM_ROUNDS(NA), .DP_LAT(LA), .TIMEOUT(TMO)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (a_if.slave)
  );

  aes_round_ctrl #(.NUM_ROUNDS(NB), .DP_LAT(LB), .TIMEOUT(TMO)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (b_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath models: the issue strobe comes back DP_LAT cycles later; flush empties the chain.
  always @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) pipe_a <= '0;
    else if (a_if.dp_flush_o) pipe_a <= '0;
    else pipe_a <= (pipe_a << 1) | LA'(a_if.dp_valid_o);
  end

  always @(posedge clk or negedge rst_n_b) begin
    if (!rst_n_b) pipe_b <= '0;
    else if (b_if.dp_flush_o) pipe_b <= '0;
    else pipe_b <= (pipe_b << 1) | LB'(b_if.dp_valid_o);
  end

  assign a_if.dp_valid_i = (pipe_a[LA-1] & ~kill_a) | inject_a;
  assign b_if.dp_valid_i = pipe_b[LB-1];

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: round r issues at c0+1+(r-1)(L+1); result valid at c0+N(L+1)+1.
  task automatic push_a(input int c0, input int upto, input bit done);
    for (int r = 1; r <= upto; r++) iq_a.push_back('{c0 + 1 + (r - 1) * (LA + 1), r});
    if (done) dq_a.push_back(c0 + NA * (LA + 1) + 1);
  endtask

  task automatic push_b(input int c0, input int upto, input bit done);
    for (int r = 1; r <= upto; r++) iq_b.push_back('{c0 + 1 + (r - 1) * (LB + 1), r});
    if (done) dq_b.push_back(c0 + NB * (LB + 1) + 1);
  endtask

  // Monitors: pop the scoreboard on every issue strobe and every rising out_valid_o.
  initial begin : mon_a
    logic ov_prev;
    iss_t e;
    int   d;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n_a === 1'b1) begin
        if (a_if.dp_valid_o) begin
          check_b("a_issue_expected", iq_a.size() > 0, 1'b1);
          if (iq_a.size() > 0) begin
            e = iq_a.pop_front();
            check_i("a_issue_cycle", cyc, e.cyc);
            check_i("a_issue_round", int'(a_if.round_o), e.round);
            check_b("a_mc_bypass", a_if.mc_bypass_o, e.round == NA);
          end
        end
        if (a_if.out_valid_o && !ov_prev) begin
          check_b("a_done_expected", dq_a.size() > 0, 1'b1);
          if (dq_a.size() > 0) begin
            d = dq_a.pop_front();
            check_i("a_done_cycle", cyc, d);
            check_b("a_done_bypass", a_if.mc_bypass_o, 1'b1);
          end
        end
        ov_prev = a_if.out_valid_o;
      end else begin
        ov_prev = 1'b0;
      end
    end
  end

  initial begin : mon_b
    logic ov_prev;
    iss_t e;
    int   d;
    ov_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n_b === 1'b1) begin
        if (b_if.dp_valid_o) begin
          check_b("b_issue_expected", iq_b.size() > 0, 1'b1);
          if (iq_b.size() > 0) begin
            e = iq_b.pop_front();
            check_i("b_issue_cycle", cyc, e.cyc);
            check_i("b_issue_round", int'(b_if.round_o), e.round);
            check_b("b_mc_bypass", b_if.mc_bypass_o, e.round == NB);
          end
        end
        if (b_if.out_valid_o && !ov_prev) begin
          check_b("b_done_expected", dq_b.size() > 0, 1'b1);
          if (dq_b.size() > 0) begin
            d = dq_b.pop_front();
            check_i("b_done_cycle", cyc, d);
          end
        end
        ov_prev = b_if.out_valid_o;
      end else begin
        ov_prev = 1'b0;
      end
    end
  end

  task automatic acc_a(input int upto, input bit done, output int c0);
    @(negedge clk);
    a_if.in_valid_i = 1'b1;
    #1;
    check_b("a_in_ready", a_if.in_ready_o, 1'b1);
    check_b("a_load", a_if.load_o, 1'b1);
    check_b("a_dp_en_accept", a_if.dp_en_o, 1'b1);
    c0 = cyc;
    push_a(c0, upto, done);
    @(negedge clk);
    a_if.in_valid_i = 1'b0;
  endtask

  task automatic finish_a(input int hold);
    int n;
    n = 0;
    while (!a_if.out_valid_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_b("a_done_seen", a_if.out_valid_o, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      check_b("a_hold_valid", a_if.out_valid_o, 1'b1);
      check_b("a_hold_dp_en", a_if.dp_en_o, 1'b0);
      check_b("a_hold_in_ready", a_if.in_ready_o, 1'b0);
      check_i("a_hold_round", int'(a_if.round_o), NA);
    end
    @(negedge clk);
    a_if.out_ready_i = 1'b1;
    @(negedge clk);
    a_if.out_ready_i = 1'b0;
    #1;
    check_b("a_idle_in_ready", a_if.in_ready_o, 1'b1);
    check_b("a_idle_out_valid", a_if.out_valid_o, 1'b0);
    check_i("a_idle_round", int'(a_if.round_o), 0);
  endtask

  task automatic drv_a();
    int c0;
    #1;
    check_i("a_rst_round", int'(a_if.round_o), 0);
    check_b("a_rst_load", a_if.load_o, 1'b0);
    check_b("a_rst_dp_en", a_if.dp_en_o, 1'b0);
    check_b("a_rst_dp_valid", a_if.dp_valid_o, 1'b0);
    check_b("a_rst_flush", a_if.dp_flush_o, 1'b0);
    check_b("a_rst_out_valid", a_if.out_valid_o, 1'b0);
    check_b("a_rst_err", a_if.err_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;

    acc_a(NA, 1'b1, c0);
    finish_a(20);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      acc_a(NA, 1'b1, c0);
      finish_a(int'($urandom_range(0, 6)));
    end

    // Abort in the WAIT phase of round 5 (issued at c0+21).
    acc_a(5, 1'b0, c0);
    repeat (22) @(negedge clk);
    a_if.abort_i = 1'b1;
    #1;
    check_b("a_abort_blocks_ready", a_if.in_ready_o, 1'b0);
    check_i("a_abort_round5", int'(a_if.round_o), 5);
    @(negedge clk);
    a_if.abort_i = 1'b0;
    #1;
    check_i("a_abort_round", int'(a_if.round_o), 0);
    check_b("a_abort_flush", a_if.dp_flush_o, 1'b1);
    check_b("a_abort_in_ready", a_if.in_ready_o, 1'b1);
    check_b("a_abort_out_valid", a_if.out_valid_o, 1'b0);
    @(negedge clk);
    inject_a = 1'b1;
    #1;
    check_b("a_abort_flush_end", a_if.dp_flush_o, 1'b0);
    @(negedge clk);
    inject_a = 1'b0;
    #1;
    check_b("a_late_valid_ignored", a_if.dp_valid_o, 1'b0);
    check_b("a_late_in_ready", a_if.in_ready_o, 1'b1);
    acc_a(NA, 1'b1, c0);
    finish_a(0);

    // Round 3 never returns: 64 WAIT cycles c0+12..c0+75, error and flush at c0+76.
    acc_a(3, 1'b0, c0);
    repeat (11) @(negedge clk);
    kill_a = 1'b1;
    repeat (63) @(negedge clk);
    #1;
    check_b("a_tmo_err_early", a_if.err_o, 1'b0);
    check_b("a_tmo_wait_en", a_if.dp_en_o, 1'b1);
    @(negedge clk);
    #1;
    check_b("a_tmo_err", a_if.err_o, 1'b1);
    check_b("a_tmo_flush", a_if.dp_flush_o, 1'b1);
    check_i("a_tmo_round", int'(a_if.round_o), 0);
    check_b("a_tmo_in_ready", a_if.in_ready_o, 1'b1);
    @(negedge clk);
    kill_a = 1'b0;
    #1;
    check_b("a_tmo_flush_end", a_if.dp_flush_o, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    check_b("a_tmo_err_sticky", a_if.err_o, 1'b1);
    acc_a(NA, 1'b1, c0);
    #1;
    check_b("a_err_cleared", a_if.err_o, 1'b0);
    finish_a(2);

    // Abort and request in the same IDLE cycle.
    @(negedge clk);
    a_if.in_valid_i = 1'b1;
    a_if.abort_i    = 1'b1;
    #1;
    check_b("a_same_in_ready", a_if.in_ready_o, 1'b0);
    check_b("a_same_load", a_if.load_o, 1'b0);
    check_b("a_same_dp_en", a_if.dp_en_o, 1'b0);
    @(negedge clk);
    a_if.in_valid_i = 1'b0;
    a_if.abort_i    = 1'b0;
    #1;
    check_b("a_same_stays_idle", a_if.in_ready_o, 1'b1);
    check_b("a_same_no_issue", a_if.dp_valid_o, 1'b0);
    check_i("a_same_round", int'(a_if.round_o), 0);
  endtask

  task automatic run_b(input int upto, input bit done, output int c0);
    @(negedge clk);
    b_if.in_valid_i = 1'b1;
    #1;
    check_b("b_load", b_if.load_o, 1'b1);
    c0 = cyc;
    push_b(c0, upto, done);
    @(negedge clk);
    b_if.in_valid_i = 1'b0;
  endtask

  task automatic finish_b();
    int n;
    n = 0;
    while (!b_if.out_valid_o && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_b("b_done_seen", b_if.out_valid_o, 1'b1);
    @(negedge clk);
    b_if.out_ready_i = 1'b1;
    @(negedge clk);
    b_if.out_ready_i = 1'b0;
    #1;
    check_b("b_idle_in_ready", b_if.in_ready_o, 1'b1);
  endtask

  task automatic drv_b();
    int c0;
    repeat (3) @(negedge clk);
    rst_n_b = 1'b1;
    run_b(NB, 1'b1, c0);
    finish_b();

    // Reset in the WAIT phase of round 7 (issued at c0+13).
    run_b(7, 1'b0, c0);
    repeat (13) @(negedge clk);
    rst_n_b = 1'b0;
    #1;
    check_i("b_rst_round", int'(b_if.round_o), 0);
    check_b("b_rst_load", b_if.load_o, 1'b0);
    check_b("b_rst_dp_en", b_if.dp_en_o, 1'b0);
    check_b("b_rst_dp_valid", b_if.dp_valid_o, 1'b0);
    check_b("b_rst_flush", b_if.dp_flush_o, 1'b0);
    check_b("b_rst_out_valid", b_if.out_valid_o, 1'b0);
    check_b("b_rst_err", b_if.err_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_n_b = 1'b1;
    run_b(NB, 1'b1, c0);
    finish_b();
  endtask

  initial begin
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    kill_a = 1'b0;
    inject_a = 1'b0;
    a_if.in_valid_i = 1'b0;
    a_if.abort_i = 1'b0;
    a_if.out_ready_i = 1'b0;
    b_if.in_valid_i = 1'b0;
    b_if.abort_i = 1'b0;
    b_if.out_ready_i = 1'b0;
    fork
      drv_a();
      drv_b();
    join
    repeat (3) @(negedge clk);
    check_i("a_issue_queue_drained", iq_a.size(), 0);
    check_i("a_done_queue_drained", dq_a.size(), 0);
    check_i("b_issue_queue_drained", iq_b.size(), 0);
    check_i("b_done_queue_drained", dq_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "time limit");
  end

endmodule
